simple_alu: RTL and testbench
=============================

# simple_alu

Registered 32-bit ALU for the datapath execute stage. Selects a second operand from a register, immediate or shifted register, performs one of eleven arithmetic/logic/shift operations, and gates result and flag write-back with an ARM-style condition code evaluated against incoming flags. Outputs a 33-bit result (carry in bit 32) and a 4-bit flag register one cycle after the inputs are sampled.

## Interface
- No parameters; datapath width fixed at 32.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- R1  in  32  operand A
- R2  in  32  register operand B source
- op_code  in  4  operation select
- Imm  in  16  immediate / shift amount
- Cond  in  4  condition code
- SR_Control  in  3  operand-B source select
- S  in  1  set-flags enable
- FLG  out  4  flag register {N,Z,C,V} = [3:0]
- flags  in  4  flags used for condition evaluation, {N,Z,C,V}
- out  out  33  result register; [32] = carry out, [31:0] = result

## Operation
- Operand B (SR_Control):
  - 0 = R2
  - 1 = sign-extended Imm
  - 2 = R2 << Imm[4:0]
  - 3 = R2 >> Imm[4:0] (logical)
  - 4–7 = R2
- op_code:
  - 0 ADD A+B
  - 1 SUB A−B
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 MOV B
  - 6 MVN ~B
  - 7 LSL A<<B[4:0]
  - 8 LSR A>>B[4:0]
  - 9 ASR A>>>B[4:0]
  - 10 CMP: SUB, out not written, flags always written regardless of S
  - 11–15 reserved: out written 0, flags never written
- Carry (out[32] and C):
  - ADD: unsigned carry out.
  - SUB/CMP: NOT borrow, so C=1 when A ≥ B unsigned.
  - Logic and MOV/MVN: 0.
  - Shifts: last bit shifted out; 0 if amount 0.
- N = result[31]; Z = (result[31:0]==0).
- V: signed overflow for ADD/SUB/CMP; 0 for all other ops.
- Cond vs flags input:
  - 0 AL, 1 EQ(Z), 2 NE, 3 CS(C), 4 CC, 5 MI(N), 6 PL, 7 VS(V), 8 VC
  - 9 HI(C&!Z), 10 LS, 11 GE(N==V), 12 LT, 13 GT(!Z&N==V), 14 LE, 15 NV (never)
- Condition pass: out updates (except CMP); FLG updates when S=1 or op is CMP.
- Condition fail: out and FLG hold their previous values.

## Timing
- All inputs sampled on rising clk; out/FLG valid one cycle later (latency 1, throughput 1 per cycle).
- rst_n low: out=0, FLG=0 immediately, independent of clk. Sampling resumes on the first rising edge after rst_n deasserts.
- Reset asserted mid-stream discards the in-flight operation.
- FLG is internal state. The flags input is not fed back internally; the integrator connects it, typically from FLG.

## Configuration
- SIMPLE_ALU_COND_EN defined: conditional execution per the Cond table above.
- Undefined: Cond is ignored and every operation executes as AL.

## Structure
- Shared package simple_alu_pkg holds:
  - op_code enum (OP_ADD … OP_CMP)
  - SR_Control enum (SRC_REG, SRC_IMM, SRC_LSL, SRC_LSR)
  - Cond enum (COND_AL … COND_NV)
  - flag bit index constants FLG_N=3, FLG_Z=2, FLG_C=1, FLG_V=0
- One sub-module, simple_alu_cond: combinational condition check taking Cond and flags, producing pass.

## Test plan
- Reset: rst_n=0 with arbitrary inputs → out=0, FLG=0000 without a clock edge.
- ADD with S=0: R1=5, R2=3, SR_Control=0, op=0, Cond=0 → out=8 next cycle, FLG stays 0000.
- SUB with S=1: R1=3, R2=5, op=1 → out[31:0]=0xFFFFFFFE, out[32]=0, FLG=1000. Then R1=5, R2=2 → out=0x1_00000003.
- Immediate operand: SR_Control=1, Imm=0xFFFF, R1=3, op=0, S=1 → out=0x1_00000002, FLG=0010.
- Shifted operand: SR_Control=2, Imm=4, R2=2, op=5 → out=32. With op=10 (CMP), R1=32 → out unchanged, FLG=0110.
- Conditions (macro defined): Cond=1 (EQ), flags=0000, any op → out/FLG hold. Cond=1, flags=0100 → executes. Cond=15 → always holds.

Source files
------------

// File: rtl/simple_alu_pkg.sv
// Shared types and constants for the simple_alu execute-stage datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package simple_alu_pkg;

  localparam int DATA_W = 32;

  // Operation select
  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_MOV = 4'd5,
    OP_MVN = 4'd6,
    OP_LSL = 4'd7,
    OP_LSR = 4'd8,
    OP_ASR = 4'd9,
    OP_CMP = 4'd10
  } op_t;

  // Operand-B source select; codes 4-7 behave as SRC_REG
  typedef enum logic [2:0] {
    SRC_REG = 3'd0,
    SRC_IMM = 3'd1,
    SRC_LSL = 3'd2,
    SRC_LSR = 3'd3
  } src_t;

  // ARM-style condition codes
  typedef enum logic [3:0] {
    COND_AL = 4'd0,
    COND_EQ = 4'd1,
    COND_NE = 4'd2,
    COND_CS = 4'd3,
    COND_CC = 4'd4,
    COND_MI = 4'd5,
    COND_PL = 4'd6,
    COND_VS = 4'd7,
    COND_VC = 4'd8,
    COND_HI = 4'd9,
    COND_LS = 4'd10,
    COND_GE = 4'd11,
    COND_LT = 4'd12,
    COND_GT = 4'd13,
    COND_LE = 4'd14,
    COND_NV = 4'd15
  } cond_t;

  // Bit positions inside the {N,Z,C,V} flag nibble
  localparam int FLG_N = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

endpackage

// File: rtl/simple_alu_if.sv
// Operand/control/result bundle between the issue logic and simple_alu.
// Latency: n/a (wires only).
// Backpressure: none; the ALU accepts one operation every cycle.
interface simple_alu_if;

  logic [31:0] R1;
  logic [31:0] R2;
  logic [3:0]  op_code;
  logic [15:0] Imm;
  logic [3:0]  Cond;
  logic [2:0]  SR_Control;
  logic        S;
  logic [3:0]  flags;
  logic [3:0]  FLG;
  logic [32:0] out;

  // Issue side: drives operands, observes results
  modport master (
    output R1, R2, op_code, Imm, Cond, SR_Control, S, flags,
    input  FLG, out
  );

  // ALU side
  modport slave (
    input  R1, R2, op_code, Imm, Cond, SR_Control, S, flags,
    output FLG, out
  );

endinterface

// File: rtl/simple_alu_cond.sv
// Condition-code check of Cond against an {N,Z,C,V} flag nibble.
// Latency: 0 (pure combinational).
// Backpressure: none.
module simple_alu_cond
  import simple_alu_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       pass_o
);

  logic n, z, c, v;

  assign n = flags_i[FLG_N];
  assign z = flags_i[FLG_Z];
  assign c = flags_i[FLG_C];
  assign v = flags_i[FLG_V];

  // Decode condition against the supplied flags
  always_comb begin
    pass_o = 1'b0;
    case (cond_i)
      COND_AL: pass_o = 1'b1;
      COND_EQ: pass_o = z;
      COND_NE: pass_o = ~z;
      COND_CS: pass_o = c;
      COND_CC: pass_o = ~c;
      COND_MI: pass_o = n;
      COND_PL: pass_o = ~n;
      COND_VS: pass_o = v;
      COND_VC: pass_o = ~v;
      COND_HI: pass_o = c & ~z;
      COND_LS: pass_o = ~c | z;
      COND_GE: pass_o = (n == v);
      COND_LT: pass_o = (n != v);
      COND_GT: pass_o = ~z & (n == v);
      COND_LE: pass_o = z | (n != v);
      default: pass_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/simple_alu.sv
// Registered 32-bit ALU: operand-B select, 11 ops, condition-gated write-back.
// Latency: 1 cycle from input sample to out/FLG; throughput 1 op per cycle.
// Backpressure: none. SIMPLE_ALU_COND_EN enables conditional execution; otherwise all ops run as AL.
module simple_alu
  import simple_alu_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  simple_alu_if.slave  alu
);

  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] opb;
  logic [4:0]        sh;
  logic [DATA_W:0]   add_t;
  logic [DATA_W:0]   sub_t;
  logic [DATA_W:0]   lsl_t;
  logic [DATA_W:0]   lsr_t;
  logic signed [DATA_W:0] asr_t;

  logic [DATA_W-1:0] res;
  logic              cout;
  logic              ovf;
  logic              wr_out;
  logic              wr_flg;
  logic [3:0]        flg_new;
  logic              pass;

  logic [DATA_W:0]   out_q, out_d;
  logic [3:0]        flg_q, flg_d;

  assign a  = alu.R1;
  assign sh = opb[4:0];

`ifdef SIMPLE_ALU_COND_EN
  simple_alu_cond u_cond (
    .cond_i  (alu.Cond),
    .flags_i (alu.flags),
    .pass_o  (pass)
  );
`else
  // Condition inputs are intentionally ignored in this build
  logic unused_cond;
  assign unused_cond = ^{alu.Cond, alu.flags};
  assign pass        = 1'b1;
`endif

  // Operand-B selection from register, sign-extended immediate or shifted register
  always_comb begin
    opb = alu.R2;
    case (alu.SR_Control)
      SRC_IMM: opb = {{16{alu.Imm[15]}}, alu.Imm};
      SRC_LSL: opb = alu.R2 << alu.Imm[4:0];
      SRC_LSR: opb = alu.R2 >> alu.Imm[4:0];
      default: opb = alu.R2;
    endcase
  end

  // Shifts are done one bit wider so the last bit shifted out lands in a fixed
  // position (bit 32 for left, bit 0 for right); a zero shift leaves it 0.
  always_comb begin
    add_t = {1'b0, a} + {1'b0, opb};
    sub_t = {1'b0, a} - {1'b0, opb};
    lsl_t = {1'b0, a} << sh;
    lsr_t = {a, 1'b0} >> sh;
    asr_t = $signed({a, 1'b0}) >>> sh;
  end

  // Result, carry, overflow and write-enable decode
  always_comb begin
    res    = '0;
    cout   = 1'b0;
    ovf    = 1'b0;
    wr_out = 1'b1;
    wr_flg = alu.S;
    case (alu.op_code)
      OP_ADD: begin
        res  = add_t[DATA_W-1:0];
        cout = add_t[DATA_W];
        ovf  = (a[31] == opb[31]) && (res[31] != a[31]);
      end
      OP_SUB, OP_CMP: begin
        res  = sub_t[DATA_W-1:0];
        cout = ~sub_t[DATA_W];          // carry = NOT borrow
        ovf  = (a[31] != opb[31]) && (res[31] != a[31]);
        if (alu.op_code == OP_CMP) begin
          wr_out = 1'b0;
          wr_flg = 1'b1;
        end
      end
      OP_AND: res = a & opb;
      OP_OR:  res = a | opb;
      OP_XOR: res = a ^ opb;
      OP_MOV: res = opb;
      OP_MVN: res = ~opb;
      OP_LSL: begin
        res  = lsl_t[DATA_W-1:0];
        cout = lsl_t[DATA_W];
      end
      OP_LSR: begin
        res  = lsr_t[DATA_W:1];
        cout = lsr_t[0];
      end
      OP_ASR: begin
        res  = asr_t[DATA_W:1];
        cout = asr_t[0];
      end
      default: begin
        // Reserved opcodes clear the result and never touch the flags
        res    = '0;
        wr_flg = 1'b0;
      end
    endcase
    flg_new = {res[31], (res == '0), cout, ovf};
  end

  // Next-state for result and flag registers, holding on condition fail
  always_comb begin
    out_d = out_q;
    flg_d = flg_q;
    if (pass && wr_out) out_d = {cout, res};
    if (pass && wr_flg) flg_d = flg_new;
  end

  // Result and flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      flg_q <= '0;
    end else begin
      out_q <= out_d;
      flg_q <= flg_d;
    end
  end

  assign alu.out = out_q;
  assign alu.FLG = flg_q;

endmodule

// File: tb/tb_simple_alu.sv
// Directed self-checking bench for simple_alu.
// Latency expected: 1 cycle.
// Backpressure: none exercised.
module tb_simple_alu;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  simple_alu_if alu_if ();

  simple_alu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .alu   (alu_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_out(input string tag, input logic [32:0] exp);
    checks++;
    assert (alu_if.out === exp) else begin
      errors++;
      $error("FAIL %s out observed=%h expected=%h", tag, alu_if.out, exp);
    end
  endtask

  task automatic chk_flg(input string tag, input logic [3:0] exp);
    checks++;
    assert (alu_if.FLG === exp) else begin
      errors++;
      $error("FAIL %s FLG observed=%b expected=%b", tag, alu_if.FLG, exp);
    end
  endtask

  // Apply one operation on the falling edge, return 1ns after the next rising edge
  task automatic run(input logic [31:0] r1, input logic [31:0] r2, input logic [3:0] op,
                     input logic [15:0] imm, input logic [2:0] src, input logic s,
                     input logic [3:0] cond, input logic [3:0] fl);
    @(negedge clk);
    alu_if.R1 = r1;  alu_if.R2 = r2;  alu_if.op_code = op;
    alu_if.Imm = imm; alu_if.SR_Control = src; alu_if.S = s;
    alu_if.Cond = cond; alu_if.flags = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    alu_if.R1 = 32'hDEAD_BEEF; alu_if.R2 = 32'h1234_5678; alu_if.op_code = 4'd0;
    alu_if.Imm = 16'h00FF; alu_if.SR_Control = 3'd0; alu_if.S = 1'b0;
    alu_if.Cond = 4'd0; alu_if.flags = 4'd0;

    // Reset without any clock edge
    #2;
    chk_out("reset", 33'h0);
    chk_flg("reset", 4'b0000);
    #2 rst_n = 1'b1;

    // ADD, S=0
    run(32'd5, 32'd3, 4'd0, 16'h0, 3'd0, 1'b0, 4'd0, 4'd0);
    chk_out("add_s0", 33'd8);
    chk_flg("add_s0", 4'b0000);

    // Asynchronous reset mid-stream
    rst_n = 1'b0;
    #1;
    chk_out("midreset", 33'h0);
    chk_flg("midreset", 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;

    // SUB with borrow, then without
    run(32'd3, 32'd5, 4'd1, 16'h0, 3'd0, 1'b1, 4'd0, 4'd0);
    chk_out("sub_neg", 33'h0_FFFF_FFFE);
    chk_flg("sub_neg", 4'b1000);
    run(32'd5, 32'd2, 4'd1, 16'h0, 3'd0, 1'b1, 4'd0, 4'd0);
    chk_out("sub_pos", 33'h1_0000_0003);
    chk_flg("sub_pos", 4'b0010);

    // Sign-extended immediate
    run(32'd3, 32'd0, 4'd0, 16'hFFFF, 3'd1, 1'b1, 4'd0, 4'd0);
    chk_out("imm_add", 33'h1_0000_0002);
    chk_flg("imm_add", 4'b0010);

    // Shifted operand MOV, then CMP
    run(32'd0, 32'd2, 4'd5, 16'd4, 3'd2, 1'b0, 4'd0, 4'd0);
    chk_out("mov_lsl", 33'd32);
    chk_flg("mov_lsl", 4'b0010);
    run(32'd32, 32'd2, 4'd10, 16'd4, 3'd2, 1'b0, 4'd0, 4'd0);
    chk_out("cmp", 33'd32);
    chk_flg("cmp", 4'b0110);

    // Logical-right-shifted operand
    run(32'd0, 32'h100, 4'd5, 16'd4, 3'd3, 1'b1, 4'd0, 4'd0);
    chk_out("mov_lsr", 33'h10);
    chk_flg("mov_lsr", 4'b0000);

    // Logic ops
    run(32'hF0F0, 32'hFF00, 4'd2, 16'h0, 3'd0, 1'b1, 4'd0, 4'd0);
    chk_out("and", 33'hF000);
    chk_flg("and", 4'b0000);
    run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd4, 16'h0, 3'd0, 1'b1, 4'd0, 4'd0);
    chk_out("xor", 33'h0);
    chk_flg("xor", 4'b0100);
    run(32'h0F, 32'hF0, 4'd3, 16'h0, 3'd0, 1'b0, 4'd0, 4'd0);
    chk_out("or", 33'hFF);
    chk_flg("or", 4'b0100);
    run(32'h0, 32'h0, 4'd6, 16'h0, 3'd0, 1'b1, 4'd0, 4'd0);
    chk_out("mvn", 33'h0_FFFF_FFFF);
    chk_flg("mvn", 4'b1000);

    // Shifts, including zero amount (B[4:0]=0)
    run(32'h8000_0001, 32'd1, 4'd7, 16'h0, 3'd0, 1'b1, 4'd0, 4'd0);
    chk_out("lsl", 33'h1_0000_0002);
    chk_flg("lsl", 4'b0010);
    run(32'h8000_0000, 32'h20, 4'd7, 16'h0, 3'd0, 1'b1, 4'd0, 4'd0);
    chk_out("lsl0", 33'h0_8000_0000);
    chk_flg("lsl0", 4'b1000);
    run(32'd3, 32'd1, 4'd8, 16'h0, 3'd0, 1'b1, 4'd0, 4'd0);
    chk_out("lsr", 33'h1_0000_0001);
    chk_flg("lsr", 4'b0010);
    run(32'h8000_0008, 32'd4, 4'd9, 16'h0, 3'd0, 1'b1, 4'd0, 4'd0);
    chk_out("asr", 33'h1_F800_0000);
    chk_flg("asr", 4'b1010);

    // Signed overflow on SUB and ADD
    run(32'h8000_0000, 32'd1, 4'd1, 16'h0, 3'd0, 1'b1, 4'd0, 4'd0);
    chk_out("sub_ovf", 33'h1_7FFF_FFFF);
    chk_flg("sub_ovf", 4'b0011);

    // Reserved op: result cleared, flags untouched even with S=1
    run(32'd7, 32'd9, 4'd12, 16'h0, 3'd0, 1'b1, 4'd0, 4'd0);
    chk_out("rsvd", 33'h0);
    chk_flg("rsvd", 4'b0011);

    run(32'h7FFF_FFFF, 32'd1, 4'd0, 16'h0, 3'd0, 1'b1, 4'd0, 4'd0);
    chk_out("add_ovf", 33'h0_8000_0000);
    chk_flg("add_ovf", 4'b1001);

`ifdef SIMPLE_ALU_COND_EN
    // EQ with Z clear: hold
    run(32'd1, 32'd1, 4'd0, 16'h0, 3'd0, 1'b1, 4'd1, 4'b0000);
    chk_out("eq_fail", 33'h0_8000_0000);
    chk_flg("eq_fail", 4'b1001);
    // EQ with Z set: execute
    run(32'd1, 32'd1, 4'd0, 16'h0, 3'd0, 1'b1, 4'd1, 4'b0100);
    chk_out("eq_pass", 33'd2);
    chk_flg("eq_pass", 4'b0000);
    // NV: never
    run(32'd2, 32'd2, 4'd0, 16'h0, 3'd0, 1'b1, 4'd15, 4'b0100);
    chk_out("nv", 33'd2);
    chk_flg("nv", 4'b0000);
    // GE with N==V: execute
    run(32'd3, 32'd3, 4'd1, 16'h0, 3'd0, 1'b1, 4'd11, 4'b1001);
    chk_out("ge_pass", 33'h1_0000_0000);
    chk_flg("ge_pass", 4'b0110);
    // LT with N==V: hold
    run(32'd1, 32'd1, 4'd0, 16'h0, 3'd0, 1'b1, 4'd12, 4'b1001);
    chk_out("lt_fail", 33'h1_0000_0000);
    chk_flg("lt_fail", 4'b0110);
`else
    // Cond ignored: NV and failing EQ still execute
    run(32'd1, 32'd1, 4'd0, 16'h0, 3'd0, 1'b1, 4'd15, 4'b0000);
    chk_out("nv_ign", 33'd2);
    chk_flg("nv_ign", 4'b0000);
    run(32'd2, 32'd2, 4'd0, 16'h0, 3'd0, 1'b0, 4'd1, 4'b0000);
    chk_out("eq_ign", 33'd4);
    chk_flg("eq_ign", 4'b0000);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
